// File: rtl/sample_src_arbiter.sv
// sample_src_arbiter: two-source audio sample arbiter with a single-entry
// registered output stage (EMPTY/FULL) that drains and refills with no bubble.
// Contention policy is chosen at compile time:
//   SAMPLE_ARB_RR_EN defined   -> round-robin (grant the source not last granted)
//   SAMPLE_ARB_RR_EN undefined -> fixed priority (src0 always wins)
module sample_src_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       src0_val,
    input  logic [7:0] src0_data,
    output logic       src0_rdy,
    input  logic       src1_val,
    input  logic [7:0] src1_data,
    output logic       src1_rdy,
    output logic       out_val,
    output logic [7:0] out_data,
    input  logic       out_rdy,
    output logic       sel,
    output logic       out_src
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_grant;    // source granted most recently (reset: src1, so src0 wins first)
    logic sel_q;         // select value held across cycles with no grant
    logic can_load;
    logic contend_pick;  // source chosen when both are valid
    logic any_gnt;

    // State register: EMPTY until a sample is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, handshakes, mux select and next state; data inputs never
    // reach the ready outputs.
    always_comb begin
        state_nxt    = state;
        src0_rdy     = 1'b0;
        src1_rdy     = 1'b0;
        sel          = sel_q;
        any_gnt      = 1'b0;
        can_load     = rst_n && ((state == EMPTY) || out_rdy);
`ifdef SAMPLE_ARB_RR_EN
        contend_pick = ~last_grant;
`else
        // last_grant is still tracked so both builds share the same state.
        contend_pick = last_grant & 1'b0;
`endif
        if (can_load) begin
            if (src0_val && src1_val) begin
                src0_rdy = ~contend_pick;
                src1_rdy = contend_pick;
            end else begin
                src0_rdy = src0_val;
                src1_rdy = src1_val;
            end
        end
        any_gnt = src0_rdy | src1_rdy;
        if (any_gnt) begin
            sel       = src1_rdy;
            state_nxt = FULL;
        end else if ((state == FULL) && out_rdy) begin
            state_nxt = EMPTY;
        end
    end

    // Output register and grant history: load on a granted handshake only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            sel_q      <= 1'b0;
        end else if (any_gnt) begin
            out_data   <= sel ? src1_data : src0_data;
            out_src    <= sel;
            last_grant <= sel;
            sel_q      <= sel;
        end
    end

    assign out_val = (state == FULL);

endmodule

// File: tb/tb_sample_src_arbiter.sv
// Directed self-checking bench for sample_src_arbiter (either policy build).
`timescale 1ns/1ps
module tb_sample_src_arbiter;

    logic       clk;
    logic       rst_n;
    logic       src0_val;
    logic [7:0] src0_data;
    logic       src0_rdy;
    logic       src1_val;
    logic [7:0] src1_data;
    logic       src1_rdy;
    logic       out_val;
    logic [7:0] out_data;
    logic       out_rdy;
    logic       sel;
    logic       out_src;

    int unsigned vectors;
    int unsigned miscompares;

    sample_src_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src0_val  (src0_val),
        .src0_data (src0_data),
        .src0_rdy  (src0_rdy),
        .src1_val  (src1_val),
        .src1_data (src1_data),
        .src1_rdy  (src1_rdy),
        .out_val   (out_val),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .sel       (sel),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held with both sources offering: nothing may be granted.
    task automatic test_reset();
        rst_n = 1'b0;
        src0_val = 1'b1; src0_data = 8'hEE;
        src1_val = 1'b1; src1_data = 8'hDD;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_val !== 1'b0) begin miscompares++; $display("FAIL reset_out_val got %b exp 0", out_val); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL reset_out_src got %b exp 0", out_src); end
        vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL reset_sel got %b exp 0", sel); end
        vectors++; if ({src0_rdy, src1_rdy} !== 2'b00) begin miscompares++; $display("FAIL reset_rdy got %b%b exp 00", src0_rdy, src1_rdy); end
        src0_val = 1'b0; src1_val = 1'b0;
        rst_n = 1'b1;
    endtask

    // Single src0 sample: grant in cycle 0, output in cycle 1, then drain.
    task automatic test_single();
        src0_val = 1'b1; src0_data = 8'h3C; out_rdy = 1'b1;
        #1;
        vectors++; if ({src0_rdy, src1_rdy} !== 2'b10) begin miscompares++; $display("FAIL single_rdy got %b%b exp 10", src0_rdy, src1_rdy); end
        vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL single_sel got %b exp 0", sel); end
        @(posedge clk); #1;
        src0_val = 1'b0;
        vectors++; if (out_val !== 1'b1) begin miscompares++; $display("FAIL single_out_val got %b exp 1", out_val); end
        vectors++; if (out_data !== 8'h3C) begin miscompares++; $display("FAIL single_out_data got %h exp 3c", out_data); end
        vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL single_out_src got %b exp 0", out_src); end
        @(posedge clk); #1;
        vectors++; if (out_val !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b exp 0", out_val); end
    endtask

    // src1-only stream 01..08, one per cycle, then drain with sel holding 1.
    task automatic test_back_to_back();
        out_rdy = 1'b1;
        src1_val = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            src1_data = 8'(i);
            #1;
            vectors++; if ({src0_rdy, src1_rdy} !== 2'b01) begin miscompares++; $display("FAIL b2b_rdy[%0d] got %b%b exp 01", i, src0_rdy, src1_rdy); end
            @(posedge clk); #1;
            vectors++; if ({out_val, out_src, out_data} !== {1'b1, 1'b1, 8'(i)}) begin
                miscompares++; $display("FAIL b2b_out[%0d] got val=%b src=%b data=%h exp val=1 src=1 data=%h", i, out_val, out_src, out_data, 8'(i));
            end
        end
        src1_val = 1'b0;
        #1;
        vectors++; if (sel !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_sel got %b exp 1", sel); end
        @(posedge clk); #1;
        vectors++; if (out_val !== 1'b0) begin miscompares++; $display("FAIL drain_out_val got %b exp 0", out_val); end
        vectors++; if (out_data !== 8'h08) begin miscompares++; $display("FAIL drain_out_data got %h exp 08", out_data); end
        vectors++; if (sel !== 1'b1) begin miscompares++; $display("FAIL drain_sel got %b exp 1", sel); end
    endtask

    // Both valid for 6 cycles, last grant was src1.
    task automatic test_contention();
        logic [7:0] exp_data;
        logic [1:0] exp_rdy;
        src0_val = 1'b1; src0_data = 8'hA1;
        src1_val = 1'b1; src1_data = 8'h5E;
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef SAMPLE_ARB_RR_EN
            exp_data = (i % 2 == 0) ? 8'hA1 : 8'h5E;
            exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_data = 8'hA1;
            exp_rdy  = 2'b10;
`endif
            #1;
            vectors++; if ({src0_rdy, src1_rdy} !== exp_rdy) begin miscompares++; $display("FAIL contend_rdy[%0d] got %b%b exp %b", i, src0_rdy, src1_rdy, exp_rdy); end
            @(posedge clk); #1;
            vectors++; if (out_data !== exp_data) begin miscompares++; $display("FAIL contend_data[%0d] got %h exp %h", i, out_data, exp_data); end
        end
    endtask

    // Hold 77 under backpressure, then refill with no bubble.
    task automatic test_stall();
        logic [7:0] exp_data;
        src0_val = 1'b1; src0_data = 8'h77;
        src1_val = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        vectors++; if (out_data !== 8'h77) begin miscompares++; $display("FAIL stall_load got %h exp 77", out_data); end
        out_rdy = 1'b0;
        src0_data = 8'h11;
        src1_val = 1'b1; src1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if ({src0_rdy, src1_rdy} !== 2'b00) begin miscompares++; $display("FAIL stall_rdy[%0d] got %b%b exp 00", i, src0_rdy, src1_rdy); end
            @(posedge clk); #1;
            vectors++; if ({out_val, out_data} !== {1'b1, 8'h77}) begin miscompares++; $display("FAIL stall_hold[%0d] got val=%b data=%h exp val=1 data=77", i, out_val, out_data); end
        end
        out_rdy = 1'b1;
`ifdef SAMPLE_ARB_RR_EN
        exp_data = 8'h22;
`else
        exp_data = 8'h11;
`endif
        @(posedge clk); #1;
        vectors++; if ({out_val, out_data} !== {1'b1, exp_data}) begin miscompares++; $display("FAIL stall_refill got val=%b data=%h exp val=1 data=%h", out_val, out_data, exp_data); end
        src0_val = 1'b0; src1_val = 1'b0;
        @(posedge clk); #1;
    endtask

    // Asynchronous reset between edges while FULL; src0 wins afterwards.
    task automatic test_reset_mid();
        src0_val = 1'b1; src0_data = 8'h5A; out_rdy = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({out_val, out_data} !== {1'b1, 8'h5A}) begin miscompares++; $display("FAIL midrst_pre got val=%b data=%h exp val=1 data=5a", out_val, out_data); end
        src1_val = 1'b1; src1_data = 8'h5E;
        out_rdy = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++; if ({out_val, out_data, out_src} !== {1'b0, 8'h00, 1'b0}) begin miscompares++; $display("FAIL midrst_async got val=%b data=%h src=%b exp val=0 data=00 src=0", out_val, out_data, out_src); end
        vectors++; if ({src0_rdy, src1_rdy, sel} !== 3'b000) begin miscompares++; $display("FAIL midrst_rdy got %b%b sel=%b exp 00 sel=0", src0_rdy, src1_rdy, sel); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        src0_data = 8'hA1;
        #1;
        vectors++; if ({src0_rdy, src1_rdy, sel} !== 3'b100) begin miscompares++; $display("FAIL postrst_grant got %b%b sel=%b exp 10 sel=0", src0_rdy, src1_rdy, sel); end
        @(posedge clk); #1;
        vectors++; if ({out_val, out_data, out_src} !== {1'b1, 8'hA1, 1'b0}) begin miscompares++; $display("FAIL postrst_out got val=%b data=%h src=%b exp val=1 data=a1 src=0", out_val, out_data, out_src); end
        src0_val = 1'b0; src1_val = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        src0_val = 1'b0; src0_data = '0;
        src1_val = 1'b0; src1_data = '0;
        out_rdy = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sample_src_arbiter.md
SAMPLE_SRC_ARBITER -- requirements
Module: sample_src_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 src0_val  input  1  source 0 (tone generator) offers a sample.
REQ-005 src0_data  input  8  source 0 sample.
REQ-006 src0_rdy  output  1  source 0 sample accepted this cycle when src0_val is also high.
REQ-007 src1_val  input  1  source 1 (playback) offers a sample.
REQ-008 src1_data  input  8  source 1 sample.
REQ-009 src1_rdy  output  1  source 1 sample accepted this cycle when src1_val is also high.
REQ-010 out_val  output  1  output register holds a sample.
REQ-011 out_data  output  8  registered selected sample.
REQ-012 out_rdy  input  1  downstream (PWM/DAC) accepts out_data when out_val is also high.
REQ-013 sel  output  1  combinational mux select for the current-cycle grant (0 = src0, 1 = src1); drives the 2:1 8-bit sample mux.
REQ-014 out_src  output  1  source of the sample currently in the output register.

Function
REQ-015 FSM states: EMPTY (out_val=0) and FULL (out_val=1).
REQ-016 can_load = EMPTY, or FULL with out_rdy=1 (drain and refill in the same cycle, zero bubble).
REQ-017 Arbitration SHALL run only when can_load=1; at most one of src0_rdy/src1_rdy is high per cycle, and neither is high when can_load=0.
REQ-018 Only one source valid: that source SHALL be granted.
REQ-019 Both valid: the grant SHALL follow the policy in REQ-030/REQ-031.
REQ-020 A granted handshake SHALL load the selected data into out_data, set out_src, and set the state to FULL on the next edge; latency is 1 cycle from source handshake to out_val.
REQ-021 FULL with out_rdy=1 and no source valid: go to EMPTY; out_data holds its last value.
REQ-022 FULL with out_rdy=0: out_data, out_src and the state SHALL hold; both rdy outputs are 0.
REQ-023 When no grant is made, sel SHALL hold its last granted value; a granted cycle updates last_grant to the granted source.
REQ-024 src*_rdy SHALL depend combinationally only on state, out_rdy, src0_val, src1_val and last_grant; it SHALL NOT depend on the data inputs.

Reset
REQ-025 While rst_n=0: state=EMPTY, out_val=0, out_data=8'h00, out_src=0, last_grant=1 (src0 wins the first contention), sel=0, src0_rdy=0, src1_rdy=0.
REQ-026 Asserting reset mid-transfer SHALL discard the held sample immediately, without waiting for a clock edge.
REQ-027 The first grant after rst_n deasserts SHALL occur no earlier than the first rising edge at which rst_n is high.

Configuration
REQ-028 Macro SAMPLE_ARB_RR_EN SHALL select the contention policy at compile time.
REQ-029 The macro SHALL NOT change any port or any behaviour outside contention.
REQ-030 With SAMPLE_ARB_RR_EN defined (round-robin): on contention, grant the source not equal to last_grant.
REQ-031 Without SAMPLE_ARB_RR_EN (fixed priority): on contention, always grant src0; last_grant is still maintained.

Verification
REQ-032 Reset then src0_val=1, src0_data=8'h3C, out_rdy=1: src0_rdy=1, sel=0 in cycle 0; out_val=1, out_data=8'h3C, out_src=0 in cycle 1.
REQ-033 Both sources valid with constant data 8'hA1 / 8'h5E, out_rdy=1 for 6 cycles:
 - RR build: out_data sequence A1,5E,A1,5E,A1,5E.
 - Fixed build: all six are A1 and src1_rdy stays 0.
REQ-034 Output FULL with 8'h77 and out_rdy=0 for 4 cycles while both sources are valid: out_data stays 77, both rdy outputs stay 0; on out_rdy=1, the new sample appears the next cycle with no bubble.
REQ-035 FULL, out_rdy=1, both sources invalid: out_val=0 in the next cycle; sel holds its previous value.
REQ-036 rst_n driven low between clock edges while FULL: out_val=0 and out_data=8'h00 immediately; after release, src0 wins the first contention.
REQ-037 Back-to-back src1-only traffic 8'h01..8'h08 with out_rdy=1 every cycle: 8 samples in 8 consecutive cycles with no gaps, each with out_src=1.
